// File: rtl/pe_dbuf_acc.sv
// Systolic PE with a double-buffered weight, WS/OS/DRAIN compute modes and saturating accumulate.
// Optional macro PE_PIPE_MUL_EN registers the multiplier, giving a 2-cycle WS path and right path.
module pe_dbuf_acc #(
    parameter int DATA_W = 9,
    parameter int W_W    = 9,
    parameter int ACC_W  = 32
) (
    input  logic              PE_clk,
    input  logic              PE_rst_n,
    input  logic [1:0]        PE_mode,
    input  logic              PE_clr,
    input  logic              PE_valid_up,
    input  logic [ACC_W-1:0]  PE_data_up,
    output logic              PE_valid_down,
    output logic [ACC_W-1:0]  PE_data_down,
    input  logic              PE_valid_left,
    input  logic [DATA_W-1:0] PE_data_left,
    input  logic              PE_swap_left,
    output logic              PE_valid_right,
    output logic [DATA_W-1:0] PE_data_right,
    output logic              PE_swap_right,
    output logic              PE_sat,
    output logic              PE_err
);

    typedef enum logic [1:0] {
        MODE_WS    = 2'b00,
        MODE_LOAD  = 2'b01,
        MODE_OS    = 2'b10,
        MODE_DRAIN = 2'b11
    } mode_t;

    localparam int P_W = DATA_W + W_W;
    // Sum width covers both operands even if ACC_W is narrower than the product.
    localparam int S_W = ((P_W > ACC_W) ? P_W : ACC_W) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic logic [S_W-1:0] ext_p(input logic [P_W-1:0] p);
        return {{(S_W-P_W){p[P_W-1]}}, p};
    endfunction

    function automatic logic [S_W-1:0] ext_a(input logic [ACC_W-1:0] a);
        return {{(S_W-ACC_W){a[ACC_W-1]}}, a};
    endfunction

    // Returns {clamped, value}.
    function automatic logic [ACC_W:0] sat_fn(input logic [S_W-1:0] s);
        logic ovf;
        ovf = ~(&s[S_W-1:ACC_W-1]) & (|s[S_W-1:ACC_W-1]);
        if (ovf) return {1'b1, (s[S_W-1] ? ACC_MIN : ACC_MAX)};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    mode_t             mode;
    logic [W_W-1:0]    active_w;
    logic [W_W-1:0]    shadow_w;
    logic              shadow_full;
    logic [ACC_W-1:0]  acc;

    logic              swap_beat;
    logic              do_swap;
    logic              load_beat;
    logic [W_W-1:0]    w_eff;
    logic [P_W-1:0]    prod;

    logic              vd_n;
    logic [ACC_W-1:0]  dd_n;
    logic [ACC_W-1:0]  acc_n;
    logic              sat_n;

    logic              rv_src;
    logic [DATA_W-1:0] rd_src;
    logic              rs_src;

    logic [S_W-1:0]    ws_sum;
    logic [S_W-1:0]    os_sum;
    logic [ACC_W:0]    ws_res;
    logic [ACC_W:0]    os_res;

    assign mode      = mode_t'(PE_mode);
    assign swap_beat = PE_valid_left & PE_swap_left;
    assign do_swap   = swap_beat & shadow_full;
    assign load_beat = (mode == MODE_LOAD) & PE_valid_up;
    assign w_eff     = do_swap ? shadow_w : active_w;
    assign prod      = $signed({{W_W{PE_data_left[DATA_W-1]}}, PE_data_left})
                     * $signed({{DATA_W{w_eff[W_W-1]}}, w_eff});

    // A load in the swap cycle lands after the swap has consumed the old shadow.
    always_ff @(posedge PE_clk or negedge PE_rst_n) begin
        if (!PE_rst_n) begin
            active_w    <= '0;
            shadow_w    <= '0;
            shadow_full <= 1'b0;
            PE_err      <= 1'b0;
        end else begin
            if (do_swap) begin
                active_w    <= shadow_w;
                shadow_full <= 1'b0;
            end
            if (load_beat) begin
                shadow_w    <= PE_data_up[W_W-1:0];
                shadow_full <= 1'b1;
            end
            if (swap_beat && !shadow_full) PE_err <= 1'b1;
        end
    end

`ifdef PE_PIPE_MUL_EN
    mode_t             s1_mode;
    logic              s1_beat;
    logic [P_W-1:0]    s1_prod;
    logic              s1_vup;
    logic [ACC_W-1:0]  s1_up;
    logic              s1_clr;
    logic              s1_vl;
    logic [DATA_W-1:0] s1_dl;
    logic              s1_sw;
    logic              os_now;
    logic              clr_now;

    assign os_now  = (mode == MODE_OS) & PE_valid_left;
    assign clr_now = PE_clr & ~os_now;

    always_ff @(posedge PE_clk or negedge PE_rst_n) begin
        if (!PE_rst_n) begin
            s1_mode <= MODE_WS;
            s1_beat <= 1'b0;
            s1_prod <= '0;
            s1_vup  <= 1'b0;
            s1_up   <= '0;
            s1_clr  <= 1'b0;
            s1_vl   <= 1'b0;
            s1_dl   <= '0;
            s1_sw   <= 1'b0;
        end else begin
            s1_mode <= mode;
            s1_beat <= PE_valid_left;
            s1_prod <= prod;
            s1_vup  <= PE_valid_up;
            s1_up   <= PE_data_up;
            s1_clr  <= PE_clr & os_now;
            s1_vl   <= PE_valid_left;
            if (PE_valid_left) s1_dl <= PE_data_left;
            s1_sw   <= PE_valid_left & PE_swap_left;
        end
    end

    assign ws_sum = ext_p(s1_prod) + (s1_vup ? ext_a(s1_up) : '0);
    assign os_sum = (s1_clr ? '0 : ext_a(acc)) + ext_p(s1_prod);
    assign ws_res = sat_fn(ws_sum);
    assign os_res = sat_fn(os_sum);

    assign rv_src = s1_vl;
    assign rd_src = s1_dl;
    assign rs_src = s1_sw;

    // Stage-2 results first; 1-cycle LOAD/DRAIN beats override on collision,
    // so leave one idle cycle when switching from WS/OS into LOAD/DRAIN.
    always_comb begin
        vd_n  = 1'b0;
        dd_n  = PE_data_down;
        acc_n = acc;
        sat_n = PE_sat;
        if (s1_beat && s1_mode == MODE_OS) begin
            acc_n = os_res[ACC_W-1:0];
            if (s1_clr) sat_n = 1'b0;
            if (os_res[ACC_W]) sat_n = 1'b1;
        end
        if (s1_beat && s1_mode == MODE_WS) begin
            dd_n = ws_res[ACC_W-1:0];
            vd_n = 1'b1;
            if (ws_res[ACC_W]) sat_n = 1'b1;
        end
        if (clr_now) begin
            acc_n = '0;
            sat_n = 1'b0;
        end
        if (load_beat) begin
            dd_n = PE_data_up;
            vd_n = 1'b1;
        end
        if (mode == MODE_DRAIN && PE_valid_up) begin
            dd_n  = acc;
            vd_n  = 1'b1;
            acc_n = PE_clr ? '0 : PE_data_up;
        end
    end
`else
    assign ws_sum = ext_p(prod) + (PE_valid_up ? ext_a(PE_data_up) : '0);
    assign os_sum = (PE_clr ? '0 : ext_a(acc)) + ext_p(prod);
    assign ws_res = sat_fn(ws_sum);
    assign os_res = sat_fn(os_sum);

    assign rv_src = PE_valid_left;
    assign rd_src = PE_data_left;
    assign rs_src = PE_valid_left & PE_swap_left;

    always_comb begin
        vd_n  = 1'b0;
        dd_n  = PE_data_down;
        acc_n = acc;
        sat_n = PE_sat;
        if (PE_clr) begin
            acc_n = '0;
            sat_n = 1'b0;
        end
        unique case (mode)
            MODE_LOAD: begin
                if (PE_valid_up) begin
                    dd_n = PE_data_up;
                    vd_n = 1'b1;
                end
            end
            MODE_WS: begin
                if (PE_valid_left) begin
                    dd_n = ws_res[ACC_W-1:0];
                    vd_n = 1'b1;
                    if (ws_res[ACC_W]) sat_n = 1'b1;
                end
            end
            MODE_OS: begin
                if (PE_valid_left) begin
                    acc_n = os_res[ACC_W-1:0];
                    if (os_res[ACC_W]) sat_n = 1'b1;
                end
            end
            MODE_DRAIN: begin
                if (PE_valid_up) begin
                    dd_n = acc;
                    vd_n = 1'b1;
                    if (!PE_clr) acc_n = PE_data_up;
                end
            end
            default: ;
        endcase
    end
`endif

    always_ff @(posedge PE_clk or negedge PE_rst_n) begin
        if (!PE_rst_n) begin
            acc            <= '0;
            PE_sat         <= 1'b0;
            PE_valid_down  <= 1'b0;
            PE_data_down   <= '0;
            PE_valid_right <= 1'b0;
            PE_data_right  <= '0;
            PE_swap_right  <= 1'b0;
        end else begin
            acc            <= acc_n;
            PE_sat         <= sat_n;
            PE_valid_down  <= vd_n;
            PE_data_down   <= dd_n;
            PE_valid_right <= rv_src;
            if (rv_src) PE_data_right <= rd_src;
            PE_swap_right  <= rs_src;
        end
    end

endmodule

// File: tb/tb_pe_dbuf_acc.sv
// Directed vector bench for pe_dbuf_acc (single-stage build, ACC_W=16 for saturation corners).
module tb_pe_dbuf_acc;

    localparam int DW = 9;
    localparam int WW = 9;
    localparam int AW = 16;

    localparam logic [1:0] WS = 2'b00;
    localparam logic [1:0] LD = 2'b01;
    localparam logic [1:0] OS = 2'b10;
    localparam logic [1:0] DR = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic          clr;
    logic          valid_up;
    logic [AW-1:0] data_up;
    logic          valid_down;
    logic [AW-1:0] data_down;
    logic          valid_left;
    logic [DW-1:0] data_left;
    logic          swap_left;
    logic          valid_right;
    logic [DW-1:0] data_right;
    logic          swap_right;
    logic          sat;
    logic          err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pe_dbuf_acc #(.DATA_W(DW), .W_W(WW), .ACC_W(AW)) dut (
        .PE_clk(clk),
        .PE_rst_n(rst_n),
        .PE_mode(mode),
        .PE_clr(clr),
        .PE_valid_up(valid_up),
        .PE_data_up(data_up),
        .PE_valid_down(valid_down),
        .PE_data_down(data_down),
        .PE_valid_left(valid_left),
        .PE_data_left(data_left),
        .PE_swap_left(swap_left),
        .PE_valid_right(valid_right),
        .PE_data_right(data_right),
        .PE_swap_right(swap_right),
        .PE_sat(sat),
        .PE_err(err)
    );

    typedef struct {
        logic [1:0]    mode;
        logic          clr;
        logic          vup;
        logic [AW-1:0] up;
        logic          vl;
        logic [DW-1:0] l;
        logic          sw;
        logic          vd;
        logic [AW-1:0] dd;
        logic          vr;
        logic [DW-1:0] dr;
        logic          sr;
        logic          sat;
        logic          err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic [1:0] m, input logic c, input logic vu, input logic [AW-1:0] u,
                               input logic vlf, input logic [DW-1:0] lf, input logic s,
                               input logic evd, input logic [AW-1:0] edd, input logic evr,
                               input logic [DW-1:0] edr, input logic esr, input logic esat, input logic eerr);
        vec_t r;
        r.mode = m; r.clr = c; r.vup = vu; r.up = u; r.vl = vlf; r.l = lf; r.sw = s;
        r.vd = evd; r.dd = edd; r.vr = evr; r.dr = edr; r.sr = esr; r.sat = esat; r.err = eerr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic evd, input logic [AW-1:0] edd, input logic evr,
                           input logic [DW-1:0] edr, input logic esr, input logic esat, input logic eerr);
        chk($sformatf("%s.valid_down", tag), 32'(valid_down), 32'(evd));
        chk($sformatf("%s.data_down", tag), 32'(data_down), 32'(edd));
        chk($sformatf("%s.valid_right", tag), 32'(valid_right), 32'(evr));
        chk($sformatf("%s.data_right", tag), 32'(data_right), 32'(edr));
        chk($sformatf("%s.swap_right", tag), 32'(swap_right), 32'(esr));
        chk($sformatf("%s.sat", tag), 32'(sat), 32'(esat));
        chk($sformatf("%s.err", tag), 32'(err), 32'(eerr));
    endtask

    task automatic drive(input logic [1:0] m, input logic c, input logic vu, input logic [AW-1:0] u,
                         input logic vlf, input logic [DW-1:0] lf, input logic s);
        mode = m; clr = c; valid_up = vu; data_up = u;
        valid_left = vlf; data_left = lf; swap_left = s;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            mode clr vup up        vl  l       sw | vd dd        vr dr      sr sat err
        vecs.push_back(v(LD, 0, 1, 16'd3,     0, 9'd0,   0,   1, 16'd3,     0, 9'd0,   0, 0, 0));
        vecs.push_back(v(WS, 0, 1, 16'd100,   1, 9'd5,   1,   1, 16'd115,   1, 9'd5,   1, 0, 0));
        vecs.push_back(v(WS, 0, 0, 16'd0,     1, 9'd4,   0,   1, 16'd12,    1, 9'd4,   0, 0, 0));
        vecs.push_back(v(LD, 0, 1, 16'hFFFE,  0, 9'd0,   0,   1, 16'hFFFE,  0, 9'd4,   0, 0, 0));
        vecs.push_back(v(WS, 0, 1, 16'd0,     1, 9'd4,   0,   1, 16'd12,    1, 9'd4,   0, 0, 0));
        vecs.push_back(v(WS, 0, 1, 16'd0,     1, 9'd4,   1,   1, 16'hFFF8,  1, 9'd4,   1, 0, 0));
        vecs.push_back(v(WS, 0, 1, 16'd0,     1, 9'd4,   0,   1, 16'hFFF8,  1, 9'd4,   0, 0, 0));
        vecs.push_back(v(WS, 0, 1, 16'd0,     1, 9'd4,   1,   1, 16'hFFF8,  1, 9'd4,   1, 0, 1));
        vecs.push_back(v(WS, 0, 1, 16'd0,     0, 9'd0,   0,   0, 16'hFFF8,  0, 9'd4,   0, 0, 1));
        vecs.push_back(v(LD, 0, 1, 16'd7,     0, 9'd0,   0,   1, 16'd7,     0, 9'd4,   0, 0, 1));
        vecs.push_back(v(OS, 0, 0, 16'd0,     1, 9'd1,   1,   0, 16'd7,     1, 9'd1,   1, 0, 1));
        vecs.push_back(v(OS, 0, 0, 16'd0,     1, 9'd2,   0,   0, 16'd7,     1, 9'd2,   0, 0, 1));
        vecs.push_back(v(OS, 0, 0, 16'd0,     1, 9'd3,   0,   0, 16'd7,     1, 9'd3,   0, 0, 1));
        vecs.push_back(v(DR, 0, 1, 16'd0,     0, 9'd0,   0,   1, 16'd42,    0, 9'd3,   0, 0, 1));
        vecs.push_back(v(DR, 0, 1, 16'd0,     0, 9'd0,   0,   1, 16'd0,     0, 9'd3,   0, 0, 1));
        vecs.push_back(v(DR, 0, 0, 16'd0,     0, 9'd0,   0,   0, 16'd0,     0, 9'd3,   0, 0, 1));
        vecs.push_back(v(LD, 0, 1, 16'd4,     0, 9'd0,   0,   1, 16'd4,     0, 9'd3,   0, 0, 1));
        vecs.push_back(v(DR, 0, 1, 16'd50,    0, 9'd0,   0,   1, 16'd0,     0, 9'd3,   0, 0, 1));
        vecs.push_back(v(OS, 1, 0, 16'd0,     1, 9'h1FD, 1,   0, 16'd0,     1, 9'h1FD, 1, 0, 1));
        vecs.push_back(v(DR, 0, 1, 16'd0,     0, 9'd0,   0,   1, 16'hFFF4,  0, 9'h1FD, 0, 0, 1));
        vecs.push_back(v(DR, 0, 1, 16'd9,     0, 9'd0,   0,   1, 16'd0,     0, 9'h1FD, 0, 0, 1));
        vecs.push_back(v(DR, 1, 1, 16'd5,     0, 9'd0,   0,   1, 16'd9,     0, 9'h1FD, 0, 0, 1));
        vecs.push_back(v(DR, 0, 1, 16'd0,     0, 9'd0,   0,   1, 16'd0,     0, 9'h1FD, 0, 0, 1));
        vecs.push_back(v(LD, 0, 1, 16'd255,   0, 9'd0,   0,   1, 16'd255,   0, 9'h1FD, 0, 0, 1));
        vecs.push_back(v(WS, 0, 1, 16'h7FFF,  1, 9'hFF,  1,   1, 16'h7FFF,  1, 9'hFF,  1, 1, 1));
        vecs.push_back(v(WS, 0, 1, 16'h8000,  1, 9'h100, 0,   1, 16'h8000,  1, 9'h100, 0, 1, 1));
        vecs.push_back(v(WS, 1, 0, 16'd0,     0, 9'd0,   0,   0, 16'h8000,  0, 9'h100, 0, 0, 1));
        vecs.push_back(v(OS, 0, 0, 16'd0,     1, 9'hFF,  0,   0, 16'h8000,  1, 9'hFF,  0, 1, 1));
        vecs.push_back(v(DR, 0, 1, 16'd0,     0, 9'd0,   0,   1, 16'h7FFF,  0, 9'hFF,  0, 1, 1));
        vecs.push_back(v(WS, 1, 0, 16'd0,     0, 9'd0,   0,   0, 16'h7FFF,  0, 9'hFF,  0, 0, 1));
        vecs.push_back(v(LD, 0, 1, 16'd6,     0, 9'd0,   0,   1, 16'd6,     0, 9'hFF,  0, 0, 1));
        vecs.push_back(v(LD, 0, 1, 16'd10,    1, 9'd2,   1,   1, 16'd10,    1, 9'd2,   1, 0, 1));
        vecs.push_back(v(WS, 0, 0, 16'd0,     1, 9'd2,   1,   1, 16'd20,    1, 9'd2,   1, 0, 1));
        vecs.push_back(v(WS, 0, 0, 16'd0,     1, 9'd2,   0,   1, 16'd20,    1, 9'd2,   0, 0, 1));

        rst_n = 1'b0;
        drive(WS, 0, 0, '0, 0, '0, 0);
        #3;
        chk_all("reset", 0, '0, 0, '0, 0, 0, 0);
        #9 rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].mode, vecs[i].clr, vecs[i].vup, vecs[i].up, vecs[i].vl, vecs[i].l, vecs[i].sw);
            @(posedge clk);
            #1;
            chk_all($sformatf("v%0d", i), vecs[i].vd, vecs[i].dd, vecs[i].vr, vecs[i].dr,
                    vecs[i].sr, vecs[i].sat, vecs[i].err);
        end

        // Asynchronous reset in the middle of a WS stream (active_w=10 here).
        drive(WS, 0, 1, 16'd1, 1, 9'd5, 0);
        @(posedge clk);
        #1;
        chk_all("pre_rst", 1, 16'd51, 1, 9'd5, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("mid_rst", 0, '0, 0, '0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("held_rst", 0, '0, 0, '0, 0, 0, 0);
        #1 rst_n = 1'b1;

        // Swap with an empty shadow after reset: weight stays 0, err sets.
        drive(WS, 0, 1, 16'd7, 1, 9'd5, 1);
        @(posedge clk);
        #1;
        chk_all("post_rst_swap", 1, 16'd7, 1, 9'd5, 1, 0, 1);

        drive(WS, 0, 0, '0, 0, '0, 0);
        @(posedge clk);
        #1;
        chk_all("idle", 0, 16'd7, 0, 9'd5, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
